// File: rtl/steer_pkg.sv
// Shared types and default constants for the rider-presence / steering-enable block.
package steer_pkg;

  // Controller states. 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } state_t;

  // Default weight thresholds for a 12-bit load-cell path. The gap between
  // them is the mount/step-off hysteresis band.
  localparam logic [11:0] DEF_ON_WEIGHT  = 12'h200;
  localparam logic [11:0] DEF_OFF_WEIGHT = 12'h1C0;

  // Settle dwell: 1.3 s at 50 MHz, and a short dwell for simulation.
  localparam int unsigned SETTLE_CYC_DEF = 65_000_000;
  localparam int unsigned FAST_CYC_DEF   = 16384;

endpackage

// File: rtl/steer_en_ctrl_if.sv
// Load-cell inputs and steering-enable outputs of steer_en_ctrl.
// Signal contract: there is no valid/ready handshake. lft_ld, rght_ld and
// fast_sim are sampled on every rising clk edge; all outputs are registered
// and are valid every cycle.
interface steer_en_ctrl_if
  import steer_pkg::*;
#(
  parameter int LD_W = 12
);

  logic [LD_W-1:0] lft_ld;
  logic [LD_W-1:0] rght_ld;
  logic            fast_sim;
  logic [LD_W-1:0] ld_cell_diff;
  logic            en_steer;
  logic            rider_off;
  state_t          state_o;

  // Driver side (A2D / test stimulus).
  modport master (
    output lft_ld, rght_ld, fast_sim,
    input  ld_cell_diff, en_steer, rider_off, state_o
  );

  // Controller side.
  modport slave (
    input  lft_ld, rght_ld, fast_sim,
    output ld_cell_diff, en_steer, rider_off, state_o
  );

endinterface

// File: rtl/sat_timer.sv
// Saturating up-counter with synchronous clear. full is asserted once the
// count has reached limit-1, so a clear followed by continuous inc gives a
// dwell of exactly limit cycles before full is acted upon.
module sat_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         full
);

  logic [W-1:0] cnt;

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

  // A zero limit is treated as already full rather than underflowing limit-1.
  assign full = (limit == '0) || (cnt >= (limit - W'(1)));

endmodule

// File: rtl/steer_en_ctrl.sv
// Rider-presence and steering-enable controller. Registers the two load-cell
// readings, derives sum / |difference| and the settle and step-off
// thresholds, and runs the IDLE -> WAIT -> STEER state machine with
// registered en_steer and a one-cycle rider_off pulse.
module steer_en_ctrl
  import steer_pkg::*;
#(
  parameter int              LD_W         = 12,
  parameter logic [LD_W-1:0] ON_WEIGHT    = LD_W'(DEF_ON_WEIGHT),
  parameter logic [LD_W-1:0] OFF_WEIGHT   = LD_W'(DEF_OFF_WEIGHT),
  parameter int              SETTLE_SHIFT = 2,
  parameter int              STEP_SHIFT   = 4,
  parameter int              STEP_DB      = 4,
  parameter int              TMR_W        = 26,
  parameter int unsigned     SETTLE_CYC   = SETTLE_CYC_DEF,
  parameter int unsigned     FAST_CYC     = FAST_CYC_DEF
) (
  input logic            clk,
  input logic            rst,
  steer_en_ctrl_if.slave bus
);

  localparam int SW = $clog2(STEP_DB) + 1;

  logic [LD_W-1:0] lft_r;
  logic [LD_W-1:0] rght_r;
  logic [LD_W-1:0] diff_r;

  logic [LD_W:0]   sum;
  logic [LD_W:0]   diff_s;
  logic [LD_W:0]   diff_mag;
  logic [LD_W:0]   settle_thr;
  logic [LD_W:0]   step_thr;

  logic            on_cond;
  logic            off_cond;
  logic            settle_viol;
  logic            step_cand;

  logic [TMR_W-1:0] limit;
  logic             tmr_clr;
  logic             tmr_inc;
  logic             tmr_full;
  logic             step_clr;
  logic             step_inc;
  logic             step_full;

  state_t           state;
  logic             en_steer_r;
  logic             rider_off_r;

  // Stage 1 input registers plus the registered |lft-rght| output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_r  <= '0;
      rght_r <= '0;
      diff_r <= '0;
    end else begin
      lft_r  <= bus.lft_ld;
      rght_r <= bus.rght_ld;
      diff_r <= diff_mag[LD_W-1:0];
    end
  end

  // Sum and difference carry one extra bit so neither can overflow; all
  // threshold compares below are unsigned on LD_W+1 bits.
  always_comb begin
    sum         = {1'b0, lft_r} + {1'b0, rght_r};
    diff_s      = {1'b0, lft_r} - {1'b0, rght_r};
    diff_mag    = diff_s[LD_W] ? ((LD_W + 1)'(0) - diff_s) : diff_s;
    settle_thr  = sum >> SETTLE_SHIFT;
    step_thr    = sum - (sum >> STEP_SHIFT);
    on_cond     = sum > {1'b0, ON_WEIGHT};
    off_cond    = sum < {1'b0, OFF_WEIGHT};
    settle_viol = diff_mag > settle_thr;
    step_cand   = diff_mag > step_thr;
  end

  // Dwell limit follows fast_sim combinationally so a change takes effect at once.
  assign limit = bus.fast_sim ? TMR_W'(FAST_CYC) : TMR_W'(SETTLE_CYC);

  // Settle timer runs only in WAIT and restarts on every balance violation;
  // the step-off debouncer runs only in STEER and restarts on any clean cycle.
  always_comb begin
    tmr_clr  = (state != WAIT) || settle_viol;
    tmr_inc  = (state == WAIT);
    step_clr = (state != STEER) || !step_cand;
    step_inc = (state == STEER);
  end

  sat_timer #(.W(TMR_W)) u_settle_tmr (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .limit (limit),
    .full  (tmr_full)
  );

  sat_timer #(.W(SW)) u_step_db (
    .clk   (clk),
    .rst   (rst),
    .clr   (step_clr),
    .inc   (step_inc),
    .limit (SW'(STEP_DB)),
    .full  (step_full)
  );

  // State machine with registered Moore outputs; rider_off is set only on
  // the edge that drops a rider back to IDLE, so it lasts one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      en_steer_r  <= 1'b0;
      rider_off_r <= 1'b0;
    end else begin
      rider_off_r <= 1'b0;
      case (state)
        IDLE: begin
          en_steer_r <= 1'b0;
          if (on_cond) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (off_cond) begin
            state       <= IDLE;
            rider_off_r <= 1'b1;
          end else if (!settle_viol && tmr_full) begin
            state      <= STEER;
            en_steer_r <= 1'b1;
          end
        end
        STEER: begin
          if (off_cond) begin
            state       <= IDLE;
            en_steer_r  <= 1'b0;
            rider_off_r <= 1'b1;
          end else if (step_cand && step_full) begin
            state      <= WAIT;
            en_steer_r <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          en_steer_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ld_cell_diff = diff_r;
  assign bus.en_steer     = en_steer_r;
  assign bus.rider_off    = rider_off_r;
  assign bus.state_o      = state;

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Directed bench for steer_en_ctrl: a table of load-cell pairs for the
// difference datapath, followed by hand-written mount / settle / step-off /
// dismount / fast_sim / reset sequences with fast dwell timing.
module tb_steer_en_ctrl;
  import steer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  steer_en_ctrl_if #(.LD_W(12)) bus ();

  steer_en_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [11:0] lft;
    logic [11:0] rght;
    logic [11:0] exp_diff;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [11:0] l, input logic [11:0] r);
    bus.lft_ld  = l;
    bus.rght_ld = r;
  endtask

  // Hold reset across one edge and release it just after that edge, so the
  // next edge is the first one that samples the inputs.
  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Ticks until en_steer is seen; n is the tick count or -1 on timeout.
  task automatic wait_en(input int max, output int n, output int ro_seen);
    n       = -1;
    ro_seen = 0;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (bus.rider_off) ro_seen++;
      if (bus.en_steer) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_ticks(input int cnt, output int en_seen, output int ro_seen);
    en_seen = 0;
    ro_seen = 0;
    for (int i = 0; i < cnt; i++) begin
      tick();
      if (bus.en_steer)  en_seen++;
      if (bus.rider_off) ro_seen++;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int n;
    int ro;
    int en;
    logic [11:0] prev;

    vecs[0] = '{lft: 12'h200, rght: 12'h200, exp_diff: 12'h000};
    vecs[1] = '{lft: 12'h300, rght: 12'h080, exp_diff: 12'h280};
    vecs[2] = '{lft: 12'h010, rght: 12'h3C0, exp_diff: 12'h3B0};
    vecs[3] = '{lft: 12'hFFF, rght: 12'h000, exp_diff: 12'hFFF};
    vecs[4] = '{lft: 12'h000, rght: 12'hFFF, exp_diff: 12'hFFF};
    vecs[5] = '{lft: 12'h123, rght: 12'h456, exp_diff: 12'h333};
    vecs[6] = '{lft: 12'hFFF, rght: 12'hFFF, exp_diff: 12'h000};

    // 1: reset state, then mount after two edges
    rst          = 1'b1;
    bus.fast_sim = 1'b1;
    set_in(12'h200, 12'h200);
    #12;
    check("rst_en_steer", bus.en_steer, 0);
    check("rst_rider_off", bus.rider_off, 0);
    check("rst_state", bus.state_o, IDLE);
    check("rst_diff", bus.ld_cell_diff, 0);
    tick();
    check("rst_hold_state", bus.state_o, IDLE);
    rst = 1'b0;
    tick();
    check("mount_edge1_state", bus.state_o, IDLE);
    tick();
    check("mount_edge2_state", bus.state_o, WAIT);

    // Difference datapath: value appears two edges after it is driven.
    prev = 12'h000;
    foreach (vecs[i]) exp_q.push_back(vecs[i].exp_diff);
    for (int i = 0; i < 7; i++) begin
      set_in(vecs[i].lft, vecs[i].rght);
      tick();
      check($sformatf("diff_lag_%0d", i), bus.ld_cell_diff, prev);
      tick();
      prev = exp_q.pop_front();
      check($sformatf("diff_vec_%0d", i), bus.ld_cell_diff, prev);
    end

    // 2: fast dwell from a clean mount
    set_in(12'h180, 12'h180);
    pulse_reset();
    tick();
    check("t2_k_state", bus.state_o, IDLE);
    tick();
    check("t2_k1_state", bus.state_o, WAIT);
    check("t2_k1_en", bus.en_steer, 0);
    wait_en(20000, n, ro);
    check("t2_dwell_ticks", n, 16384);
    check("t2_rider_off_seen", ro, 0);
    check("t2_state", bus.state_o, STEER);

    // 3: settle violation holds the timer at zero
    pulse_reset();
    tick();
    tick();
    check("t3_state_wait", bus.state_o, WAIT);
    set_in(12'h300, 12'h080);
    run_ticks(20000, en, ro);
    check("t3_viol_en_seen", en, 0);
    check("t3_viol_state", bus.state_o, WAIT);
    check("t3_viol_diff", bus.ld_cell_diff, 12'h280);
    set_in(12'h180, 12'h180);
    wait_en(20000, n, ro);
    check("t3_resume_ticks", n, 16385);

    // 4a: sum inside hysteresis band keeps STEER
    set_in(12'h0F0, 12'h0F0);
    run_ticks(50, en, ro);
    check("t4_band_en_cycles", en, 50);
    check("t4_band_state", bus.state_o, STEER);

    // 5: step-off debounce, 3 candidates then 4
    set_in(12'h3C0, 12'h010);
    run_ticks(3, en, ro);
    set_in(12'h180, 12'h180);
    run_ticks(3, en, ro);
    check("t5_three_state", bus.state_o, STEER);
    set_in(12'h3C0, 12'h010);
    run_ticks(4, en, ro);
    check("t5_four_pre_state", bus.state_o, STEER);
    set_in(12'h180, 12'h180);
    tick();
    check("t5_stepoff_state", bus.state_o, WAIT);
    check("t5_stepoff_en", bus.en_steer, 0);
    check("t5_stepoff_ro", bus.rider_off, 0);

    // WAIT holds inside the band, then dismount from WAIT
    set_in(12'h0F0, 12'h0F0);
    run_ticks(20, en, ro);
    check("wait_band_state", bus.state_o, WAIT);
    set_in(12'h080, 12'h080);
    tick();
    check("wait_off_pre_state", bus.state_o, WAIT);
    tick();
    check("wait_off_state", bus.state_o, IDLE);
    check("wait_off_ro", bus.rider_off, 1);
    tick();
    check("wait_off_ro_clear", bus.rider_off, 0);
    set_in(12'h0F0, 12'h0F0);
    run_ticks(10, en, ro);
    check("idle_band_state", bus.state_o, IDLE);
    check("idle_band_ro_seen", ro, 0);

    // 6: slow dwell, switch to fast mid-WAIT
    bus.fast_sim = 1'b0;
    set_in(12'h180, 12'h180);
    pulse_reset();
    tick();
    tick();
    check("t6_state_wait", bus.state_o, WAIT);
    run_ticks(20000, en, ro);
    check("t6_slow_en_seen", en, 0);
    check("t6_slow_state", bus.state_o, WAIT);
    bus.fast_sim = 1'b1;
    tick();
    check("t6_switch_en", bus.en_steer, 1);
    check("t6_switch_state", bus.state_o, STEER);

    // 4b: dismount from STEER
    set_in(12'h080, 12'h080);
    tick();
    check("t4_off_pre_state", bus.state_o, STEER);
    tick();
    check("t4_off_state", bus.state_o, IDLE);
    check("t4_off_en", bus.en_steer, 0);
    check("t4_off_ro", bus.rider_off, 1);
    tick();
    check("t4_off_ro_clear", bus.rider_off, 0);

    // Reset mid-WAIT: immediate return, no pulse
    set_in(12'h180, 12'h180);
    tick();
    tick();
    check("rstmid_pre_state", bus.state_o, WAIT);
    run_ticks(100, en, ro);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_state", bus.state_o, IDLE);
    check("rstmid_ro", bus.rider_off, 0);
    check("rstmid_diff", bus.ld_cell_diff, 0);
    tick();
    rst = 1'b0;
    run_ticks(5, en, ro);
    check("rstmid_after_ro_seen", ro, 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
